// File: rtl/chart_pan_ctrl.sv
// Chart pan controller: turns drag deltas into frame-synchronous chart offsets.
// Optional double-click recentre is enabled with the CHART_PAN_RESET_EN macro.
//
// Ports:
//   clk          pixel clock, all logic on posedge
//   rst_n        synchronous active-low reset
//   left_mouse   left button level (already synchronous)
//   dx_mag/neg   |dx| since press anchor and its sign
//   dy_mag/neg   |dy| since press anchor and its sign
//   frame_tick   1-cycle pulse at start of vertical blank
//   x_offset     signed horizontal pan offset
//   y_offset     signed vertical pan offset
//   panning      1 while a drag is in progress
//   offset_valid 1-cycle pulse when x/y_offset were updated
module chart_pan_ctrl #(
    parameter int MAX_X         = 511,
    parameter int MAX_Y         = 255,
    parameter int DCLICK_CYCLES = 19_500_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               left_mouse,
    input  logic [10:0]        dx_mag,
    input  logic               dx_neg,
    input  logic [10:0]        dy_mag,
    input  logic               dy_neg,
    input  logic               frame_tick,
    output logic signed [11:0] x_offset,
    output logic signed [11:0] y_offset,
    output logic               panning,
    output logic               offset_valid
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAG   = 2'd1,
        COMMIT = 2'd2
    } state_e;

    function automatic logic signed [12:0] sdelta(
        input logic [10:0] mag,
        input logic        neg
    );
        logic signed [12:0] m;
        m = $signed({2'b00, mag});
        return neg ? -m : m;
    endfunction

    function automatic logic signed [11:0] clamp(
        input logic signed [12:0] v,
        input int                 lim
    );
        logic signed [12:0] hi;
        logic signed [12:0] lo;
        logic signed [12:0] r;
        hi = 13'(lim);
        lo = -hi;
        r  = v;
        if (v > hi)
            r = hi;
        else if (v < lo)
            r = lo;
        return r[11:0];
    endfunction

    state_e             state_q, state_d;
    logic               left_q;
    logic signed [11:0] base_x_q, base_x_d;
    logic signed [11:0] base_y_q, base_y_d;
    logic signed [11:0] x_off_q, x_off_d;
    logic signed [11:0] y_off_q, y_off_d;
    logic               valid_q, valid_d;
    logic               pan_q;

    logic               press;
    logic               release_e;
    logic               dclick;
    logic signed [11:0] live_x;
    logic signed [11:0] live_y;

    assign press     = left_mouse & ~left_q;
    assign release_e = ~left_mouse & left_q;

    // Live offset = committed base + delta since press, saturated.
    assign live_x = clamp({base_x_q[11], base_x_q} + sdelta(dx_mag, dx_neg), MAX_X);
    assign live_y = clamp({base_y_q[11], base_y_q} + sdelta(dy_mag, dy_neg), MAX_Y);

`ifdef CHART_PAN_RESET_EN
    localparam int CW = $clog2(DCLICK_CYCLES + 1);
    localparam logic [CW-1:0] DCLK_MAX = CW'(DCLICK_CYCLES);

    logic [CW-1:0] cnt_q;
    logic          armed_q;

    // Window is only open after a drag has been committed; a fresh
    // reset does not count as a first click.
    assign dclick = armed_q && (cnt_q < DCLK_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            if (state_q == DRAG && release_e) begin
                cnt_q   <= '0;
                armed_q <= 1'b1;
            end else begin
                if (cnt_q < DCLK_MAX)
                    cnt_q <= cnt_q + 1'b1;
                if (press && state_q != DRAG && dclick)
                    armed_q <= 1'b0;
            end
        end
    end
`else
    logic unused_dclick_cycles;
    assign unused_dclick_cycles = ^DCLICK_CYCLES;
    assign dclick = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        base_x_d = base_x_q;
        base_y_d = base_y_q;
        x_off_d  = x_off_q;
        y_off_d  = y_off_q;
        valid_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (press) begin
                    if (dclick) begin
                        base_x_d = '0;
                        base_y_d = '0;
                    end else begin
                        state_d = DRAG;
                    end
                end
            end
            DRAG: begin
                if (release_e) begin
                    state_d  = COMMIT;
                    base_x_d = live_x;
                    base_y_d = live_y;
                end
            end
            COMMIT: begin
                // left_q is 0 here, so left_mouse=1 is always a press.
                if (left_mouse && !dclick) begin
                    state_d = DRAG;
                end else begin
                    state_d = IDLE;
                    if (left_mouse) begin
                        base_x_d = '0;
                        base_y_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (frame_tick) begin
            if (state_q == DRAG) begin
                x_off_d = live_x;
                y_off_d = live_y;
                valid_d = 1'b1;
            end else begin
                x_off_d = base_x_q;
                y_off_d = base_y_q;
                valid_d = (base_x_q != x_off_q) || (base_y_q != y_off_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            left_q   <= 1'b0;
            base_x_q <= '0;
            base_y_q <= '0;
            x_off_q  <= '0;
            y_off_q  <= '0;
            valid_q  <= 1'b0;
            pan_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            left_q   <= left_mouse;
            base_x_q <= base_x_d;
            base_y_q <= base_y_d;
            x_off_q  <= x_off_d;
            y_off_q  <= y_off_d;
            valid_q  <= valid_d;
            pan_q    <= (state_d == DRAG);
        end
    end

    assign x_offset     = x_off_q;
    assign y_offset     = y_off_q;
    assign panning      = pan_q;
    assign offset_valid = valid_q;

endmodule

// File: tb/tb_chart_pan_ctrl.sv
// Self-checking bench for chart_pan_ctrl: vector table, corner
// sequences and randomized traffic against a behavioural model.
module tb_chart_pan_ctrl;

    localparam int MAX_X = 511;
    localparam int MAX_Y = 255;
    localparam int DCLK  = 100;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               left_mouse;
    logic [10:0]        dx_mag;
    logic               dx_neg;
    logic [10:0]        dy_mag;
    logic               dy_neg;
    logic               frame_tick;
    logic signed [11:0] x_offset;
    logic signed [11:0] y_offset;
    logic               panning;
    logic               offset_valid;

    int n_checks = 0;
    int n_fail   = 0;

    chart_pan_ctrl #(
        .MAX_X(MAX_X),
        .MAX_Y(MAX_Y),
        .DCLICK_CYCLES(DCLK)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .left_mouse(left_mouse),
        .dx_mag(dx_mag),
        .dx_neg(dx_neg),
        .dy_mag(dy_mag),
        .dy_neg(dy_neg),
        .frame_tick(frame_tick),
        .x_offset(x_offset),
        .y_offset(y_offset),
        .panning(panning),
        .offset_valid(offset_valid)
    );

    always #5 clk = ~clk;

    // Behavioural model: a "dragging" flag, committed base, shown offsets.
    bit m_prev, m_drag, m_valid, m_armed;
    int m_bx, m_by, m_ox, m_oy, m_since;

    function automatic int clampi(int v, int lim);
        if (v > lim) return lim;
        if (v < -lim) return -lim;
        return v;
    endfunction

    task automatic model(bit rst, bit l, int dxm, bit dxn, int dym, bit dyn, bit tk);
        int lx, ly, nox, noy;
        bit press, rel, nv, dc;
        if (!rst) begin
            m_prev = 0; m_drag = 0; m_valid = 0; m_armed = 0;
            m_bx = 0; m_by = 0; m_ox = 0; m_oy = 0; m_since = 0;
            return;
        end
        press = l && !m_prev;
        rel   = !l && m_prev;
        lx = clampi(m_bx + (dxn ? -dxm : dxm), MAX_X);
        ly = clampi(m_by + (dyn ? -dym : dym), MAX_Y);
        nox = m_ox; noy = m_oy; nv = 0;
        if (tk) begin
            if (m_drag) begin
                nox = lx; noy = ly; nv = 1;
            end else begin
                nox = m_bx; noy = m_by;
                nv = (m_bx != m_ox) || (m_by != m_oy);
            end
        end
        dc = 0;
`ifdef CHART_PAN_RESET_EN
        dc = m_armed && (m_since < DCLK);
`endif
        if (m_drag && rel) begin
            m_bx = lx; m_by = ly; m_drag = 0;
            m_since = 0; m_armed = 1;
        end else begin
            if (m_since < DCLK) m_since++;
            if (!m_drag && press) begin
                if (dc) begin
                    m_bx = 0; m_by = 0; m_armed = 0;
                end else begin
                    m_drag = 1;
                end
            end
        end
        m_ox = nox; m_oy = noy; m_valid = nv; m_prev = l;
    endtask

    task automatic step(bit rst, bit l, int dxm, bit dxn, int dym, bit dyn, bit tk);
        rst_n      = rst;
        left_mouse = l;
        dx_mag     = 11'(dxm);
        dx_neg     = dxn;
        dy_mag     = 11'(dym);
        dy_neg     = dyn;
        frame_tick = tk;
        @(posedge clk);
        model(rst, l, dxm, dxn, dym, dyn, tk);
        #1;
    endtask

    task automatic chk(string nm, int act, int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(string tag, int ex, int ey, int ev, int ep);
        chk({tag, ".x"}, int'(x_offset), ex);
        chk({tag, ".y"}, int'(y_offset), ey);
        chk({tag, ".valid"}, int'(offset_valid), ev);
        chk({tag, ".pan"}, int'(panning), ep);
    endtask

    typedef struct {
        bit l;
        int dxm; bit dxn;
        int dym; bit dyn;
        bit tk;
        int ex; int ey; int ev; int ep;
    } vec_t;

    vec_t vt[$];

    task automatic add(bit l, int dxm, bit dxn, int dym, bit dyn, bit tk,
                       int ex, int ey, int ev, int ep);
        vec_t v;
        v.l = l; v.dxm = dxm; v.dxn = dxn; v.dym = dym; v.dyn = dyn;
        v.tk = tk; v.ex = ex; v.ey = ey; v.ev = ev; v.ep = ep;
        vt.push_back(v);
    endtask

    initial begin
        // Basic drag, then COMMIT tick with unchanged base.
        add(1,   0,0,  0,0, 0,   0,  0, 0, 1);
        add(1,  40,0, 10,1, 1,  40,-10, 1, 1);
        add(1,  40,0, 10,1, 0,  40,-10, 0, 1);
        add(0,  40,0, 10,1, 0,  40,-10, 0, 0);
        add(0,   0,0,  0,0, 1,  40,-10, 0, 0);
        // Build base_x=500, then clamp and back off.
        add(1,   0,0,  0,0, 0,  40,-10, 0, 1);
        add(1, 460,0,  0,0, 0,  40,-10, 0, 1);
        add(0, 460,0,  0,0, 0,  40,-10, 0, 0);
        add(0,   0,0,  0,0, 1, 500,-10, 1, 0);
        add(1,   0,0,  0,0, 0, 500,-10, 0, 1);
        add(1, 100,0,  0,0, 1, 511,-10, 1, 1);
        add(1, 100,1,  0,0, 1, 400,-10, 1, 1);
        add(1, 100,1,  0,0, 0, 400,-10, 0, 1);
        // Deltas change without a tick: outputs hold.
        add(1,   7,0,  3,0, 0, 400,-10, 0, 1);
        add(1, 200,1, 50,1, 0, 400,-10, 0, 1);
        add(0,   0,0,  0,0, 0, 400,-10, 0, 0);
        add(0,   0,0,  0,0, 1, 500,-10, 1, 0);
        // Return base to 0.
        add(1,   0,0,  0,0, 0, 500,-10, 0, 1);
        add(1, 500,1, 10,0, 0, 500,-10, 0, 1);
        add(0, 500,1, 10,0, 0, 500,-10, 0, 0);
        add(0,   0,0,  0,0, 1,   0,  0, 1, 0);
        // Release coincident with tick.
        add(1,   0,0,  0,0, 0,   0,  0, 0, 1);
        add(0,  30,0,  0,0, 1,  30,  0, 1, 0);
        add(0,   0,0,  0,0, 0,  30,  0, 0, 0);
        add(0,   0,0,  0,0, 1,  30,  0, 0, 0);
        add(1,   0,0,  0,0, 0,  30,  0, 0, 1);
        add(1,   5,0,  0,0, 1,  35,  0, 1, 1);
        add(1,   0,0,300,1, 1,  30,-255,1, 1);
        add(1,   0,1,  0,1, 1,  30,  0, 1, 1);
        // Press during COMMIT is not lost.
        add(0,  10,0,  0,0, 0,  30,  0, 0, 0);
        add(1,   0,0,  0,0, 0,  30,  0, 0, 1);
        add(1,   0,0,  0,0, 1,  40,  0, 1, 1);

        // Reset with button held.
        step(0, 1, 9, 0, 9, 0, 1);
        step(0, 1, 9, 0, 9, 0, 1);
        chk_all("reset", 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        chk_all("post_reset", 0, 0, 0, 0);

        foreach (vt[i]) begin
            step(1, vt[i].l, vt[i].dxm, vt[i].dxn, vt[i].dym, vt[i].dyn, vt[i].tk);
            chk_all($sformatf("vec%0d", i), vt[i].ex, vt[i].ey, vt[i].ev, vt[i].ep);
        end

        // Reset mid-drag discards everything.
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 1, 77, 0, 20, 1, 1);
        chk_all("pre_rst_drag", 117, -20, 1, 1);
        step(0, 1, 77, 0, 20, 1, 0);
        chk_all("rst_drag", 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 1);
        chk_all("rst_drag_tick", 0, 0, 0, 0);

`ifdef CHART_PAN_RESET_EN
        // Double-click inside window recentres.
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 1, 40, 0, 10, 1, 1);
        step(1, 0, 40, 0, 10, 1, 0);
        repeat (49) step(1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        chk("dclick.pan", int'(panning), 0);
        step(1, 1, 0, 0, 0, 0, 1);
        chk_all("dclick.tick", 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        // Second click outside window starts a normal drag.
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 1, 40, 0, 10, 1, 1);
        step(1, 0, 40, 0, 10, 1, 0);
        repeat (149) step(1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        chk("slow.pan", int'(panning), 1);
        step(1, 1, 0, 0, 0, 0, 1);
        chk_all("slow.tick", 40, -10, 1, 1);
        step(1, 0, 0, 0, 0, 0, 0);
`endif

        // Randomized traffic against the model.
        begin
            bit l = 0;
            for (int i = 0; i < 3000; i++) begin
                bit r;
                int dxm, dym;
                r = ($urandom_range(0, 299) != 0);
                if ($urandom_range(0, 7) == 0) l = ~l;
                dxm = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 2047)
                                                  : $urandom_range(0, 300);
                dym = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 2047)
                                                  : $urandom_range(0, 300);
                step(r, l, dxm, 1'($urandom_range(0, 1)),
                     dym, 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 3) == 0));
                if (!r) l = 0;
                chk_all($sformatf("rnd%0d", i), m_ox, m_oy, int'(m_valid), int'(m_drag));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
